// File: rtl/core_pkg.sv
// Shared load/store definitions: RV32 funct3 width codes and the adapter state encoding.
package core_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LD_DATA = 2'd1,
      ST_MERGE   = 2'd2,
      ST_RESP    = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/half lane logic: load extract-and-extend and store merge into a word.
module lsu_align
   import core_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Little-endian lane selection for loads
   always_comb begin
      byte_s = 8'd0;
      case (offset_i)
         2'd0:    byte_s = word_i[7:0];
         2'd1:    byte_s = word_i[15:8];
         2'd2:    byte_s = word_i[23:16];
         2'd3:    byte_s = word_i[31:24];
         default: byte_s = 8'd0;
      endcase
      half_s = offset_i[1] ? word_i[31:16] : word_i[15:0];
   end

   // Sign/zero extension by access width
   always_comb begin
      load_data_o = 32'd0;
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   load_data_o = {24'd0, byte_s};
         F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
         F3_HU:   load_data_o = {16'd0, half_s};
         F3_W:    load_data_o = word_i;
         default: load_data_o = 32'd0;
      endcase
   end

   // Replace the addressed lane, keep the rest of the word
   always_comb begin
      merge_data_o = word_i;
      case (funct3_i)
         F3_B: begin
            case (offset_i)
               2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
               2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
               2'd2:    merge_data_o[23:16] = wdata_i[7:0];
               2'd3:    merge_data_o[31:24] = wdata_i[7:0];
               default: merge_data_o = word_i;
            endcase
         end
         F3_H: begin
            if (offset_i[1]) begin
               merge_data_o[31:16] = wdata_i;
            end else begin
               merge_data_o[15:0] = wdata_i;
            end
         end
         default: merge_data_o = word_i;
      endcase
   end

endmodule

// File: rtl/bram_lsu_adapter.sv
// RV32 load/store to single-port 32-bit BRAM adapter; sub-word stores are read-modify-write.
module bram_lsu_adapter
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_di,
   input  logic [31:0]           ram_do
);

   lsu_state_e            state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            off_q;
   logic [2:0]            f3_q;
   logic [15:0]           wdata_q;
   logic                  resp_valid_q;
   logic [31:0]           resp_rdata_q;
   logic                  resp_err_q;

   logic                  accept_s;
   logic                  legal_s;
   logic                  err_s;
   logic                  is_sw_s;
   logic [31:0]           load_data_s;
   logic [31:0]           merge_data_s;

   assign req_ready  = (state_q == ST_IDLE) && !rst;
   assign accept_s   = req_valid && req_ready;
   assign is_sw_s    = req_we && (req_funct3 == F3_W);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // Request legality: funct3 set, natural alignment, address range
   always_comb begin
      legal_s = 1'b0;
      case (req_funct3)
         F3_B, F3_H, F3_W: legal_s = 1'b1;
         F3_BU, F3_HU:     legal_s = !req_we;
         default:          legal_s = 1'b0;
      endcase
      err_s = !legal_s
           || (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
           || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
           || (req_addr[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});
   end

   lsu_align u_align (
      .word_i       (ram_do),
      .offset_i     (off_q),
      .funct3_i     (f3_q),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data_s),
      .merge_data_o (merge_data_s)
   );

   // RAM port drive; everything gated off during reset so no partial write can escape
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = {ADDR_WIDTH{1'b0}};
      ram_di   = 32'd0;
      if (rst) begin
         ram_en   = 1'b0;
         ram_we   = 1'b0;
      end else if (accept_s && !err_s) begin
         ram_en   = 1'b1;
         ram_we   = is_sw_s;
         ram_addr = req_addr[ADDR_WIDTH+1:2];
         ram_di   = is_sw_s ? req_wdata : 32'd0;
      end else if (state_q == ST_MERGE) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = addr_q;
         ram_di   = merge_data_s;
      end else begin
         ram_en   = 1'b0;
         ram_we   = 1'b0;
      end
   end

   // Control FSM with registered response channel
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= {ADDR_WIDTH{1'b0}};
         off_q        <= 2'd0;
         f3_q         <= 3'd0;
         wdata_q      <= 16'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  addr_q  <= req_addr[ADDR_WIDTH+1:2];
                  off_q   <= req_addr[1:0];
                  f3_q    <= req_funct3;
                  wdata_q <= req_wdata[15:0];
                  if (err_s || is_sw_s) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= 32'd0;
                     resp_err_q   <= err_s;
                  end else if (req_we) begin
                     state_q <= ST_MERGE;
                  end else begin
                     state_q <= ST_LD_DATA;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LD_DATA: begin
               state_q      <= ST_RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= load_data_s;
               resp_err_q   <= 1'b0;
            end
            ST_MERGE: begin
               state_q      <= ST_RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= 32'd0;
               resp_err_q   <= 1'b0;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b0;
               end else begin
                  state_q      <= ST_RESP;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bram_lsu_adapter.md
Name: bram_lsu_adapter

Overview:
- Sits between the core's load/store stage and the single-port block RAM, which has a 32-bit word, a 1-cycle registered read, a synchronous output reset, and no byte enables.
- Accepts byte-addressed RV32 load/store requests over a valid/ready handshake.
- Issues word-addressed RAM accesses and implements SB/SH as read-modify-write.
- Returns sign- or zero-extended load data and an error flag over a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 10, RAM word-address bits. Byte range is 0 .. 4*2^ADDR_WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- req_valid  in  1  request present
- req_ready  out  1  adapter can accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, in LSBs for B/H
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out of range, or illegal funct3
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_di  out  32  RAM write data
- ram_do  in  32  RAM read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- States: IDLE, LD_DATA, MERGE, RESP.
- req_ready = (state==IDLE) && !rst.
- Accept = req_valid && req_ready.
- Reset: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
- RAM outputs are combinational. While rst=1 they are forced to en=0, we=0, addr=0, di=0.
- Request fields are registered on accept: word address, byte offset addr[1:0], funct3, wdata.
- Error check, done combinationally at accept:
  - err if funct3 is not in the legal set; for stores, only 000/001/010 are legal.
  - err if H access with addr[0]=1.
  - err if W access with addr[1:0]!=0.
  - err if addr[31:ADDR_WIDTH+2]!=0.
  - On err: no RAM access (ram_en=0). Next state RESP with resp_err=1, rdata=0. resp_valid rises at T+1.
- Load, accepted at cycle T:
  - T: ram_en=1, ram_we=0, ram_addr=req_addr[ADDR_WIDTH+1:2]. Next state LD_DATA.
  - T+1 (LD_DATA): extract byte/half by offset from ram_do (little-endian; offset k selects bits 8k+7:8k). Sign-extend for B/H, zero-extend for BU/HU. Register into resp_rdata. resp_valid=1 from T+2. Next state RESP.
- SW, accepted at T:
  - T: ram_en=1, ram_we=1, ram_di=req_wdata. Next state RESP; resp_valid at T+1, rdata=0.
- SB/SH, accepted at T:
  - T: read of the word (en=1, we=0).
  - T+1 (MERGE): ram_en=1, ram_we=1, same address. ram_di = ram_do with the selected byte/half replaced by wdata[7:0]/[15:0]; other bytes are preserved.
  - Next state RESP; resp_valid at T+2.
- RESP:
  - Hold resp_valid, resp_rdata, resp_err stable until resp_ready.
  - On handshake: resp_valid<=0 and state<=IDLE. A new request is accepted the following cycle, so there is no same-cycle turnaround.
  - No RAM activity while in RESP.
- Throughput: at most one outstanding request. req_ready stays low from accept until the cycle after the response handshake.
- Reset mid-operation:
  - Any state returns to IDLE and resp_valid drops.
  - A pending MERGE write is not performed if rst is high in that cycle, because the RAM outputs are gated.
  - Memory contents are never partially updated by the adapter.
- Address mapping: ram_addr = byte_addr[ADDR_WIDTH+1:2], with no wrap-around; out-of-range addresses are errors.

Decomposition:
- Shared package (core_pkg):
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum localparams.
- Sub-module lsu_align:
  - Purely combinational byte/half extract-and-extend for loads.
  - Byte/half merge for stores.
  - Reused by the core's future cache path.
- Target size: roughly 200 lines total.

Test Plan:
- Reset, then SW addr=0x10 data=0xDEADBEEF; then LW 0x10 -> RAM word 4 = 0xDEADBEEF; LW resp_rdata=0xDEADBEEF at T+2, err=0.
- Word 4=0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB addr=0x11 data=0x55 to word 0xDEADBEEF -> exactly one write at T+1, word becomes 0xDEAD55EF; resp at T+2.
- LW 0x02, SH 0x01, LW 0x1000 (ADDR_WIDTH=10) -> each resp_err=1, rdata=0, ram_en never high, resp at T+1.
- Hold resp_ready=0 for 5 cycles after an LW -> resp_valid and rdata stable, req_ready=0; next request is accepted only after the handshake.
- SH 0x20 accepted, rst asserted in the MERGE cycle -> no RAM write observed, word 8 unchanged, state IDLE, resp_valid=0.
